serial_negate_unit: RTL and testbench

//  Multi-cycle operand conditioner for the ALU datapath: returns the bitwise complement
//  (NOT) or the two's-complement negation (NOT + 1) of a size-bit operand.

---
 rtl/serial_negate_unit_pkg.sv | 21 ++
 rtl/serial_negate_unit_neg_bit_cell.sv | 17 +
 rtl/serial_negate_unit.sv | 108 ++++++++++
 tb/tb_serial_negate_unit.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/serial_negate_unit_pkg.sv
// Shared opcode, state and sizing definitions for the serial negate unit.
// No logic of its own; constants and a width helper only.
// Nothing here carries state or handshakes.
package serial_negate_unit_pkg;

    localparam logic OP_NOT = 1'b0;
    localparam logic OP_NEG = 1'b1;

    // 2'd3 is unreachable; the FSM treats it as IDLE.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Bit counter width: enough to count to n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_negate_unit_neg_bit_cell.sv
// Single invert/half-add cell: r = ~b ^ cin, cout = ~b & cin.
// Purely combinational, zero latency.
// No handshakes; the owning FSM decides when its outputs are captured.
module neg_bit_cell (
    input  logic b,
    input  logic cin,
    output logic r,
    output logic cout
);

    logic nb;

    not g_inv (nb, b);
    xor g_sum (r, nb, cin);
    and g_cry (cout, nb, cin);

endmodule

// File: rtl/serial_negate_unit.sv
// Bit-serial NOT / two's-complement negate of a size-bit operand, LSB first.
// Latency: result valid size+1 edges after accept; one operand per size+2 cycles.
// Backpressure: result and overflow hold in DONE until out_ready; in_ready only in IDLE.
module serial_negate_unit
    import serial_negate_unit_pkg::*;
#(
    parameter int size = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            op,
    input  logic [size-1:0] in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [size-1:0] out,
    output logic            overflow
);

    localparam int            CW   = cnt_width(size);
    localparam logic [CW-1:0] LAST = CW'(size - 1);

    state_t          state;
    logic [size-1:0] sreg;
    logic [size-1:0] sreg_nxt;
    logic [CW-1:0]   cnt;
    logic            carry;
    logic            msb_in;
    logic            op_r;
    logic            r;
    logic            cout;

    // One shared cell processes the current LSB each RUN cycle.
    neg_bit_cell u_cell (
        .b    (sreg[0]),
        .cin  (carry),
        .r    (r),
        .cout (cout)
    );

    // Result bit enters at the MSB; a one-bit operand simply becomes the result bit.
    generate
        if (size == 1) begin : g_shift_1
            assign sreg_nxt = r;
        end else begin : g_shift_n
            assign sreg_nxt = {r, sreg[size-1:1]};
        end
    endgenerate

    // The shift register doubles as the result register.
    assign out = sreg;

    // Control FSM with datapath state; all outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            sreg      <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            msb_in    <= 1'b0;
            op_r      <= OP_NOT;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        sreg     <= in;
                        carry    <= op;
                        msb_in   <= in[size-1];
                        op_r     <= op;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    sreg  <= sreg_nxt;
                    carry <= cout;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        // r is the final MSB; only the most-negative input keeps it set under NEG.
                        overflow  <= (op_r == OP_NEG) & msb_in & r;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        overflow  <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    overflow  <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_negate_unit.sv
// Directed bench for serial_negate_unit at size=8 and size=1.
// Expected values are hand-computed or derived from (op ? -in : ~in).
// Drives inputs #1 after posedge and samples there too.
module tb_serial_negate_unit;

    logic       clk;
    logic       rst_n;

    logic       in_valid,  in_ready,  op,  out_valid,  out_ready,  overflow;
    logic [7:0] din, dout;

    logic       in_valid1, in_ready1, op1, out_valid1, out_ready1, overflow1;
    logic [0:0] din1, dout1;

    int checks = 0;
    int errors = 0;

    serial_negate_unit #(.size(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .op(op), .in(din),
        .out_valid(out_valid), .out_ready(out_ready), .out(dout), .overflow(overflow)
    );

    serial_negate_unit #(.size(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1), .op(op1), .in(din1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out(dout1), .overflow(overflow1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one operand to the size-8 unit and wait (bounded) for out_valid.
    task automatic do_op8(input logic o, input logic [7:0] v,
                          output logic [7:0] r, output logic f, output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 30) begin tick(); w++; end
        in_valid = 1'b1; op = o; din = v;
        tick();
        in_valid = 1'b0; op = ~o; din = 8'($urandom);
        lat = 0;
        while (!out_valid && lat < 30) begin tick(); lat++; end
        r = dout;
        f = overflow;
    endtask

    // Full transaction with out_ready high: result, flag, latency, return to IDLE.
    task automatic run8(input string tag, input logic o, input logic [7:0] v,
                        input logic [7:0] er, input logic ef);
        logic [7:0] r;
        logic       f;
        int         lat;
        out_ready = 1'b1;
        do_op8(o, v, r, f, lat);
        chk({tag, "_out"}, 32'(r), 32'(er));
        chk({tag, "_ovf"}, 32'(f), 32'(ef));
        chk({tag, "_lat"}, lat, 8);
        tick();
        chk({tag, "_idle"}, {31'd0, in_ready & ~out_valid}, 32'd1);
    endtask

    task automatic run1(input string tag, input logic o, input logic v,
                        input logic er, input logic ef);
        int lat;
        out_ready1 = 1'b1;
        in_valid1 = 1'b1; op1 = o; din1 = v;
        tick();
        in_valid1 = 1'b0; op1 = ~o; din1 = ~v;
        lat = 0;
        while (!out_valid1 && lat < 10) begin tick(); lat++; end
        chk({tag, "_out"}, 32'(dout1), 32'(er));
        chk({tag, "_ovf"}, 32'(overflow1), 32'(ef));
        chk({tag, "_lat"}, lat, 1);
        tick();
        chk({tag, "_idle"}, 32'(in_ready1), 32'd1);
    endtask

    initial begin
        logic [7:0] r, hold, v, er;
        logic       f, o;
        int         lat, pulses;

        rst_n = 1'b0;
        in_valid = 1'b0; op = 1'b0; din = 8'h00; out_ready = 1'b0;
        in_valid1 = 1'b0; op1 = 1'b0; din1 = 1'b0; out_ready1 = 1'b0;
        tick();
        tick();
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out",       32'(dout),      32'd0);
        chk("rst_overflow",  32'(overflow),  32'd0);
        chk("rst1_in_ready", 32'(in_ready1), 32'd1);
        rst_n = 1'b1;
        tick();

        // Directed operands.
        run8("neg05", 1'b1, 8'h05, 8'hFB, 1'b0);
        run8("neg80", 1'b1, 8'h80, 8'h80, 1'b1);
        run8("neg7f", 1'b1, 8'h7F, 8'h81, 1'b0);
        run8("not5a", 1'b0, 8'h5A, 8'hA5, 1'b0);
        run8("neg00", 1'b1, 8'h00, 8'h00, 1'b0);
        run8("not80", 1'b0, 8'h80, 8'h7F, 1'b0);

        // Backpressure: result held, input pulses ignored.
        out_ready = 1'b0;
        do_op8(1'b1, 8'h80, r, f, lat);
        chk("bp_out", 32'(r), 32'h80);
        chk("bp_lat", lat, 8);
        hold = dout;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; din = 8'h33; op = 1'b0;
            tick();
            in_valid = 1'b0;
            chk("bp_valid_hold", 32'(out_valid), 32'd1);
            chk("bp_out_hold",   32'(dout),      32'(hold));
            chk("bp_ovf_hold",   32'(overflow),  32'd1);
            chk("bp_in_ready",   32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_ready", 32'(in_ready),  32'd1);
        chk("bp_release_ovf",   32'(overflow),  32'd0);

        // Reset mid-RUN at cnt=4.
        in_valid = 1'b1; op = 1'b1; din = 8'hAA;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        tick();
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_ready", 32'(in_ready),  32'd1);
        chk("mid_rst_out",   32'(dout),      32'd0);
        chk("mid_rst_ovf",   32'(overflow),  32'd0);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) pulses++;
        end
        chk("mid_rst_no_pulse", pulses, 0);
        run8("neg01", 1'b1, 8'h01, 8'hFF, 1'b0);

        // size=1 unit.
        run1("s1_neg1", 1'b1, 1'b1, 1'b1, 1'b1);
        run1("s1_not0", 1'b0, 1'b0, 1'b1, 1'b0);
        run1("s1_neg0", 1'b1, 1'b0, 1'b0, 1'b0);
        run1("s1_not1", 1'b0, 1'b1, 1'b0, 1'b0);

        // Random sweep on the 8-bit unit against (op ? -in : ~in).
        for (int i = 0; i < 24; i++) begin
            v  = 8'($urandom);
            o  = 1'($urandom);
            er = o ? (8'd0 - v) : ~v;
            run8("rand", o, v, er, o && (v == 8'h80));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
